// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for JK flip-flop excitation drivers.
//   - jk_state_t      : controller state encoding (CLR / RUN / VERIFY), 2 bits
//   - JK_DEFAULT_*    : default bank width and count modulus
//   - jk_bit_drive_t  : per-bit {j, k} drive pair
//   - jk_excite_bit() : excitation for one bit, (n, q) -> {j, k}
// The excitation is per bit so any driver width can reuse it via generate-for.
// Optional feature macro used by the drivers: JK_LOAD_VERIFY_EN.
// ---------------------------------------------------------------------------
package jk_pkg;

    localparam int JK_DEFAULT_WIDTH = 4;
    localparam int JK_DEFAULT_MOD   = 10;

    typedef enum logic [1:0] {
        CLR    = 2'd0,
        RUN    = 2'd1,
        VERIFY = 2'd2
    } jk_state_t;

    typedef struct packed {
        logic j;
        logic k;
    } jk_bit_drive_t;

    // Set-only / reset-only excitation: a bit that must rise gets J, a bit
    // that must fall gets K, an unchanged bit gets neither. J=K=1 (toggle)
    // can never be produced because n & ~q and ~n & q are mutually exclusive.
    function automatic jk_bit_drive_t jk_excite_bit(input logic n, input logic q);
        jk_bit_drive_t drv;
        drv.j = n & ~q;
        drv.k = ~n & q;
        return drv;
    endfunction

endpackage

// File: rtl/jk_count_driver_if.sv
// ---------------------------------------------------------------------------
// jk_count_driver_if
// Bundle between the count controller and its surroundings (JK bank + user).
//   q    : bank Q feedback            en   : count enable
//   up   : 1 = up, 0 = down           load : parallel load request
//   d    : load value                 j/k  : registered bank excitation
//   tc   : terminal count             busy : requests are being ignored
//   err  : sticky load-verify failure
// Modports:
//   slave  - the jk_count_driver itself
//   master - the environment that feeds requests/feedback and consumes drive
// ---------------------------------------------------------------------------
interface jk_count_driver_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] q;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             tc;
    logic             busy;
    logic             err;

    modport slave (
        input  q, en, up, load, d,
        output j, k, tc, busy, err
    );

    modport master (
        output q, en, up, load, d,
        input  j, k, tc, busy, err
    );
endinterface

// File: rtl/jk_count_driver_next_value.sv
// ---------------------------------------------------------------------------
// jk_next_value
// Combinational target selection for the modulo-MOD JK counter.
// Ports:
//   i_q    : current bank state
//   i_en   : count enable (already gated by the controller when busy)
//   i_up   : count direction
//   i_load : load request (already gated), has priority over i_en
//   i_d    : load value; out-of-range values load 0
//   o_n    : target value the bank must take on the next falling edge
//   o_tc   : the counting step wraps (9->0 up, 0->9 down for MOD=10)
// ---------------------------------------------------------------------------
module jk_next_value
    import jk_pkg::*;
#(
    parameter int WIDTH = JK_DEFAULT_WIDTH,
    parameter int MOD   = JK_DEFAULT_MOD
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_n,
    output logic             o_tc
);
    // The modulus may equal 2**WIDTH, so range compares are done one bit wider.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic w_q_illegal;
    logic w_d_legal;

    assign w_q_illegal = ({1'b0, i_q} >= MOD_EXT);
    assign w_d_legal   = ({1'b0, i_d} <  MOD_EXT);

    always_comb begin
        o_n  = i_q;
        o_tc = 1'b0;
        if (i_load) begin
            o_n = w_d_legal ? i_d : '0;
        end else if (i_en && i_up) begin
            // Illegal states recover to 0 but are not a wrap, so no TC.
            if ((i_q == MAX_VAL) || w_q_illegal) begin
                o_n = '0;
            end else begin
                o_n = i_q + 1'b1;
            end
            o_tc = (i_q == MAX_VAL);
        end else if (i_en) begin
            if ((i_q == '0) || w_q_illegal) begin
                o_n = MAX_VAL;
            end else begin
                o_n = i_q - 1'b1;
            end
            o_tc = (i_q == '0);
        end
    end

endmodule

// File: rtl/jk_count_driver.sv
// ---------------------------------------------------------------------------
// jk_count_driver
// Posedge excitation controller for a negedge-clocked bank of WIDTH JK
// flip-flops. Reads the bank Q back, picks a target (load / up / down /
// hold) and drives registered J/K so the bank settles on the target at the
// following falling edge.
// Ports:
//   i_clk   : system clock (this block uses the rising edge)
//   i_rst_n : asynchronous active-low reset; forces CLR drive immediately
//   bus     : jk_count_driver_if.slave (q, en, up, load, d -> j, k, tc,
//             busy, err)
// Build option:
//   JK_LOAD_VERIFY_EN defined  : after each load a VERIFY cycle compares the
//                                bank with the latched target; mismatch sets
//                                sticky err.
//   JK_LOAD_VERIFY_EN undefined: loads take one cycle, err is tied low.
// ---------------------------------------------------------------------------
module jk_count_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = JK_DEFAULT_WIDTH,
    parameter int MOD   = JK_DEFAULT_MOD
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    jk_count_driver_if.slave   bus
);
    jk_state_t        r_state;
    jk_state_t        w_state_next;

    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_tc;
    logic [WIDTH-1:0] w_j_next;
    logic [WIDTH-1:0] w_k_next;
    logic             w_tc_next;

    logic             w_run;
    logic             w_en_gated;
    logic             w_load_gated;
    logic [WIDTH-1:0] w_n;
    logic             w_tc_calc;
    logic [WIDTH-1:0] w_j_run;
    logic [WIDTH-1:0] w_k_run;

    // Requests only take effect in RUN; in CLR/VERIFY they are dropped.
    assign w_run        = (r_state == RUN);
    assign w_en_gated   = bus.en   & w_run;
    assign w_load_gated = bus.load & w_run;

    jk_next_value #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next_value (
        .i_q    (bus.q),
        .i_en   (w_en_gated),
        .i_up   (bus.up),
        .i_load (w_load_gated),
        .i_d    (bus.d),
        .o_n    (w_n),
        .o_tc   (w_tc_calc)
    );

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
            jk_bit_drive_t w_drv;
            assign w_drv       = jk_excite_bit(w_n[gi], bus.q[gi]);
            assign w_j_run[gi] = w_drv.j;
            assign w_k_run[gi] = w_drv.k;
        end
    endgenerate

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLR: w_state_next = RUN;
`ifdef JK_LOAD_VERIFY_EN
            RUN: w_state_next = bus.load ? VERIFY : RUN;
`else
            RUN: w_state_next = RUN;
`endif
            VERIFY:  w_state_next = RUN;
            default: w_state_next = CLR;
        endcase
    end

    // ---------------- output logic ----------------
    // J/K/TC for the state being left are computed here and registered below,
    // so they are stable well before the bank's falling edge.
    always_comb begin
        w_j_next  = '0;
        w_k_next  = '0;
        w_tc_next = 1'b0;
        case (r_state)
            CLR: begin
                w_k_next = '1;
            end
            RUN: begin
                w_j_next  = w_j_run;
                w_k_next  = w_k_run;
                w_tc_next = w_tc_calc;
            end
            VERIFY: begin
                // Hold the bank still while it is being compared.
                w_j_next = '0;
                w_k_next = '0;
            end
            default: begin
                w_k_next = '1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_j  <= '0;
            r_k  <= '1;
            r_tc <= 1'b0;
        end else begin
            r_j  <= w_j_next;
            r_k  <= w_k_next;
            r_tc <= w_tc_next;
        end
    end

`ifdef JK_LOAD_VERIFY_EN
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target_next;
    logic             r_err;
    logic             w_err_next;

    // The target is latched in the load cycle; the bank has taken it by the
    // next rising edge, which is when VERIFY compares.
    always_comb begin
        w_target_next = r_target;
        w_err_next    = r_err;
        if (w_load_gated) begin
            w_target_next = w_n;
        end
        if ((r_state == VERIFY) && (bus.q != r_target)) begin
            w_err_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target <= '0;
            r_err    <= 1'b0;
        end else begin
            r_target <= w_target_next;
            r_err    <= w_err_next;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.j    = r_j;
    assign bus.k    = r_k;
    assign bus.tc   = r_tc;
    assign bus.busy = (r_state != RUN);

endmodule

// File: tb/tb_jk_count_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_count_driver
// Directed bench for jk_count_driver (WIDTH=4, MOD=10) with a behavioural
// negedge JK bank closing the Q loop. Honours JK_LOAD_VERIFY_EN.
// ---------------------------------------------------------------------------
module tb_jk_count_driver;
    import jk_pkg::*;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    jk_count_driver_if #(.WIDTH(WIDTH)) bus_if ();

    jk_count_driver #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural JK bank ----------------
    logic [WIDTH-1:0] bank_q   = 4'hF;
    logic [WIDTH-1:0] bank_nx;
    logic             stuck0   = 1'b0;
    logic             tog_seen = 1'b0;

    always @(negedge clk) begin
        bank_nx = bank_q;
        for (int b = 0; b < WIDTH; b++) begin
            case ({bus_if.j[b], bus_if.k[b]})
                2'b01:   bank_nx[b] = 1'b0;
                2'b10:   bank_nx[b] = 1'b1;
                2'b11:   bank_nx[b] = ~bank_q[b];
                default: bank_nx[b] = bank_q[b];
            endcase
        end
        if (stuck0) bank_nx[0] = 1'b0;
        bank_q <= bank_nx;
        if ((bus_if.j & bus_if.k) != '0) tog_seen <= 1'b1;
    end

    assign bus_if.q = bank_q;

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_negedge();
        @(negedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp_q;

    initial begin
        bus_if.en   = 1'b0;
        bus_if.up   = 1'b0;
        bus_if.load = 1'b0;
        bus_if.d    = '0;

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_j",    32'(bus_if.j),    32'h0);
        check("rst_k",    32'(bus_if.k),    32'hF);
        check("rst_tc",   32'(bus_if.tc),   32'h0);
        check("rst_busy", 32'(bus_if.busy), 32'h1);
        check("rst_err",  32'(bus_if.err),  32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_j", 32'(bus_if.j), 32'h0);
            check("rst_hold_k", 32'(bus_if.k), 32'hF);
        end
        rst_n = 1'b1;
        check("rel_busy", 32'(bus_if.busy), 32'h1);
        check("rel_q",    32'(bus_if.q),    32'h0);
        tick();
        check("run_busy", 32'(bus_if.busy), 32'h0);
        check("clr_k",    32'(bus_if.k),    32'hF);
        $display("reset done q=%0d busy=%0b", bus_if.q, bus_if.busy);

        // ---------------- count up 12 steps ----------------
        bus_if.en = 1'b1;
        bus_if.up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("up_tc", 32'(bus_if.tc), (i == 9) ? 32'h1 : 32'h0);
            to_negedge();
            exp_q = 4'((i + 1) % 10);
            check("up_q", 32'(bus_if.q), 32'(exp_q));
            $display("up step %0d q=%0d tc=%0b", i, bus_if.q, bus_if.tc);
        end
        bus_if.en = 1'b0;

        // ---------------- load 0 ----------------
        bus_if.load = 1'b1;
        bus_if.d    = 4'd0;
        tick();
        bus_if.load = 1'b0;
`ifdef JK_LOAD_VERIFY_EN
        check("ld0_busy", 32'(bus_if.busy), 32'h1);
`else
        check("ld0_busy", 32'(bus_if.busy), 32'h0);
`endif
        to_negedge();
        check("ld0_q", 32'(bus_if.q), 32'h0);
`ifdef JK_LOAD_VERIFY_EN
        tick();
        check("ld0_verify_busy", 32'(bus_if.busy), 32'h0);
        check("ld0_verify_err",  32'(bus_if.err),  32'h0);
        to_negedge();
`endif
        $display("load 0 q=%0d", bus_if.q);

        // ---------------- count down 3 steps ----------------
        bus_if.en = 1'b1;
        bus_if.up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dn_tc", 32'(bus_if.tc), (i == 0) ? 32'h1 : 32'h0);
            to_negedge();
            exp_q = 4'(9 - i);
            check("dn_q", 32'(bus_if.q), 32'(exp_q));
            $display("down step %0d q=%0d tc=%0b", i, bus_if.q, bus_if.tc);
        end
        bus_if.en = 1'b0;
        check("no_toggle", 32'(tog_seen), 32'h0);

        // ---------------- load 7 with EN (load wins) ----------------
        bus_if.load = 1'b1;
        bus_if.d    = 4'd7;
        bus_if.en   = 1'b1;
        bus_if.up   = 1'b1;
        tick();
        bus_if.load = 1'b0;
        bus_if.en   = 1'b0;
        check("ld7_tc", 32'(bus_if.tc), 32'h0);
        to_negedge();
        check("ld7_q", 32'(bus_if.q), 32'h7);
`ifdef JK_LOAD_VERIFY_EN
        tick();
        to_negedge();
`endif
        $display("load 7 q=%0d", bus_if.q);

        // ---------------- load 12 (out of range -> 0) ----------------
        bus_if.load = 1'b1;
        bus_if.d    = 4'd12;
        tick();
        bus_if.load = 1'b0;
        to_negedge();
        check("ld12_q", 32'(bus_if.q), 32'h0);
`ifdef JK_LOAD_VERIFY_EN
        tick();
        to_negedge();
`endif
        check("ld12_err", 32'(bus_if.err), 32'h0);
        $display("load 12 q=%0d", bus_if.q);

`ifdef JK_LOAD_VERIFY_EN
        // ---------------- stuck bit 0, load 5 -> verify fails ----------------
        stuck0      = 1'b1;
        bus_if.load = 1'b1;
        bus_if.d    = 4'd5;
        tick();
        bus_if.load = 1'b0;
        bus_if.en   = 1'b1;   // arrives in VERIFY, must be dropped
        bus_if.up   = 1'b1;
        check("vfy_busy", 32'(bus_if.busy), 32'h1);
        to_negedge();
        check("stuck_q", 32'(bus_if.q), 32'h4);
        tick();
        bus_if.en = 1'b0;
        check("vfy_err", 32'(bus_if.err), 32'h1);
        check("vfy_j",   32'(bus_if.j),   32'h0);
        check("vfy_k",   32'(bus_if.k),   32'h0);
        to_negedge();
        check("vfy_drop_q", 32'(bus_if.q), 32'h4);
        stuck0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("err_sticky", 32'(bus_if.err), 32'h1);
        end
        $display("verify fail q=%0d err=%0b", bus_if.q, bus_if.err);
`else
        // ---------------- load 5 then count ----------------
        bus_if.load = 1'b1;
        bus_if.d    = 4'd5;
        tick();
        bus_if.load = 1'b0;
        bus_if.en   = 1'b1;
        bus_if.up   = 1'b1;
        check("ld5_busy", 32'(bus_if.busy), 32'h0);
        to_negedge();
        check("ld5_q",   32'(bus_if.q),   32'h5);
        check("ld5_err", 32'(bus_if.err), 32'h0);
        tick();
        bus_if.en = 1'b0;
        to_negedge();
        check("ld5_cnt_q", 32'(bus_if.q), 32'h6);
        $display("load 5 then count q=%0d", bus_if.q);
`endif

        // ---------------- async reset right after a load ----------------
        bus_if.load = 1'b1;
        bus_if.d    = 4'd3;
        tick();
        bus_if.load = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_j",    32'(bus_if.j),    32'h0);
        check("arst_k",    32'(bus_if.k),    32'hF);
        check("arst_err",  32'(bus_if.err),  32'h0);
        check("arst_busy", 32'(bus_if.busy), 32'h1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_run_busy", 32'(bus_if.busy), 32'h0);
        check("arst_q",        32'(bus_if.q),    32'h0);
        $display("async reset q=%0d busy=%0b", bus_if.q, bus_if.busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_count_driver.md
# jk_count_driver

- Synchronous excitation controller for a bank of negedge-clocked JK flip-flops. It turns a modulo-MOD up/down count, a parallel load and a post-load check into per-bit J/K drive.
- It sits directly upstream of the JK register bank. It drives the bank's J and K inputs and reads the bank's Q outputs back as its state.
- J/K are registered on the rising edge, so they are stable when the bank samples on the following falling edge.

## Interface
- WIDTH, 4, number of JK flip-flops driven (bits of count).
- MOD, 10, count modulus; legal count values 0..MOD-1; 2 <= MOD <= 2**WIDTH.
- CLK  input  1  system clock; this block acts on posedge, the JK bank acts on negedge.
- RST_N  input  1  reset, asynchronous, active-low.
- Q  input  WIDTH  feedback from the JK bank outputs.
- EN  input  1  count enable.
- UP  input  1  1 = count up, 0 = count down.
- LOAD  input  1  parallel load request; has priority over EN.
- D  input  WIDTH  load value.
- J  output  WIDTH  J drive to the bank, registered.
- K  output  WIDTH  K drive to the bank, registered.
- TC  output  1  terminal count: high in the cycle a wrap excitation is driven, registered.
- BUSY  output  1  high while LOAD/EN are ignored.
- ERR  output  1  sticky load-verify failure.

## Operation
- Target n selection, evaluated from Q at each posedge:
  - LOAD: n = D if D < MOD, else 0.
  - else EN & UP: n = (Q == MOD-1 || Q >= MOD) ? 0 : Q+1.
  - else EN & ~UP: n = (Q == 0 || Q >= MOD) ? MOD-1 : Q-1.
  - else: n = Q.
  - Illegal Q (>= MOD) while counting always recovers to 0 going up and MOD-1 going down.
- Excitation per bit i: J[i] = n[i] & ~Q[i], K[i] = ~n[i] & Q[i]. Toggle (J=K=1) is never emitted. Unchanged bits get J=K=0.
- TC = 1 when counting (not loading) and the step wraps: UP with Q == MOD-1, or DOWN with Q == 0.
- FSM states:
  - CLR: entered on reset. Drives J=0, K=all-ones, BUSY=1. After the first posedge with RST_N high, goes to RUN.
  - RUN: normal excitation per rules above, BUSY=0. LOAD goes to VERIFY (macro only), otherwise stays in RUN.
  - VERIFY: J=K=0, BUSY=1. Compares Q with the latched load target n. Mismatch sets ERR. Returns to RUN after one cycle.
- EN and LOAD are sampled but ignored while BUSY=1. No queueing.

## Timing
- Reset values: state=CLR, J=0, K={WIDTH{1}}, TC=0, BUSY=1, ERR=0. The bank is therefore cleared to 0 on negedges during reset.
- Latency: a request sampled at posedge t produces J/K valid after t. The bank updates at the negedge of cycle t. The new Q is visible at posedge t+1. One count step per cycle.
- Back-to-back EN cycles count every cycle. LOAD followed by EN: with the macro, the EN in the VERIFY cycle is dropped; without it, EN at t+1 counts from the loaded value.
- RST_N assertion mid-operation forces CLR values immediately, whatever the state. A pending VERIFY is abandoned and ERR is cleared.
- ERR holds until RST_N is low.

## Configuration
- JK_LOAD_VERIFY_EN defined: VERIFY state present; LOAD costs 2 cycles (BUSY high in the second); ERR is live.
- Undefined: no VERIFY state and no latched target; LOAD is a single RUN cycle; ERR is tied 0; BUSY is high only in CLR.

## Structure
- Shared package jk_pkg holds:
  - state enum {CLR, RUN, VERIFY} with a 2-bit encoding;
  - default WIDTH/MOD constants;
  - the excitation function (n, q) -> {j, k}, reused by other JK drivers.
- One natural sub-module, jk_next_value: combinational computation of n and TC from Q, EN, UP, LOAD, D. The FSM and output registers live in jk_count_driver.

## Test plan
All scenarios use WIDTH=4, MOD=10, with a behavioural negedge JK bank on J/K/Q.
- Reset with bank Q=4'hF, RST_N low for 3 cycles, then released -> J=0, K=4'hF throughout reset; Q=0 before the first RUN cycle; BUSY falls 1 cycle after release.
- EN=1, UP=1 for 12 cycles from Q=0 -> Q sequence 1..9, 0, 1, 2; TC high exactly in the cycle driving 9->0.
- EN=1, UP=0 from Q=0 -> Q=9, 8, 7; TC high on the 0->9 step; J/K never both 1 on any bit.
- LOAD=1, D=7 with EN=1 in the same cycle -> Q=7 (load wins). LOAD with D=12 -> Q=0.
- With the macro, force the bank model to stick bit 0 at 0, then LOAD D=5 -> Q=4, ERR=1 one cycle later, ERR stays high until reset. Without the macro, ERR=0 and EN at the next cycle counts 5->6.
- Assert RST_N low during the VERIFY cycle -> J=0, K=4'hF, ERR=0, BUSY=1 immediately (asynchronous).
